// File: rtl/ibex_pkg.sv
// Shared Ibex types: OBI-to-AXI bridge FSM states, AXI constants
// and the AXI4 request/response bundles used by ibex_axi.
package ibex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AWW,
    ST_B
  } obi2axi_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0010;

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic        user;
  } axi_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        user;
  } axi_w_t;

  typedef struct packed {
    logic       id;
    logic [1:0] resp;
    logic       user;
  } axi_b_t;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_t;

endpackage

// File: rtl/ibex_obi2axi.sv
// OBI -> AXI4 bridge, one single-beat 32-bit transaction in flight.
// Ports: clk_i/rst_i (sync, active-high), OBI req/gnt/we/be/addr/wdata,
// rvalid/rdata/err response, axi_req_o/axi_rsp_i AXI bundles.
// Build option: OBI2AXI_ERR_EN reports resp[1] on err_o.
module ibex_obi2axi
  import ibex_pkg::*;
#(
  parameter logic AXI_ID   = 1'b0,
  parameter logic IS_INSTR = 1'b0,
  parameter type  axi_req_t = ibex_pkg::axi_req_t,
  parameter type  axi_rsp_t = ibex_pkg::axi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output axi_req_t    axi_req_o,
  input  axi_rsp_t    axi_rsp_i
);

  obi2axi_state_e state_q;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        ar_valid_q;
  logic        r_ready_q;
  logic        aw_valid_q;
  logic        w_valid_q;
  logic        b_ready_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic aw_hs;
  logic w_hs;
  logic aw_ok;
  logic w_ok;

  assign aw_hs = aw_valid_q & axi_rsp_i.aw_ready;
  assign w_hs  = w_valid_q & axi_rsp_i.w_ready;
  // a handshake this cycle counts as done for the B decision
  assign aw_ok = aw_done_q | aw_hs;
  assign w_ok  = w_done_q | w_hs;

  assign gnt_o    = (state_q == ST_IDLE) & req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

`ifdef OBI2AXI_ERR_EN
  logic err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  logic unused_in;
  assign unused_in = ^{axi_rsp_i, addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
`ifdef OBI2AXI_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            addr_q  <= {addr_i[31:2], 2'b00};
            be_q    <= be_i;
            wdata_q <= wdata_i;
            if (we_i) begin
              state_q    <= ST_AWW;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              aw_done_q  <= 1'b0;
              w_done_q   <= 1'b0;
            end else begin
              state_q    <= ST_AR;
              ar_valid_q <= 1'b1;
            end
          end
        end
        ST_AR: begin
          if (axi_rsp_i.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= ST_R;
          end
        end
        ST_R: begin
          if (axi_rsp_i.r_valid) begin
            r_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            state_q   <= ST_IDLE;
`ifdef OBI2AXI_ERR_EN
            err_q   <= axi_rsp_i.r.resp[1];
            rdata_q <= axi_rsp_i.r.resp[1] ? '0 : axi_rsp_i.r.data;
`else
            rdata_q <= axi_rsp_i.r.data;
`endif
          end
        end
        ST_AWW: begin
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_hs) begin
            w_valid_q <= 1'b0;
            w_done_q  <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            b_ready_q <= 1'b1;
            state_q   <= ST_B;
          end
        end
        ST_B: begin
          if (axi_rsp_i.b_valid) begin
            b_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= '0;
            state_q   <= ST_IDLE;
`ifdef OBI2AXI_ERR_EN
            err_q <= axi_rsp_i.b.resp[1];
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = AXI_ID;
    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.size  = AXI_SIZE_4B;
    axi_req_o.aw.burst = AXI_BURST_INCR;
    axi_req_o.aw.cache = AXI_CACHE_DEF;
    axi_req_o.aw.prot  = {IS_INSTR, 2'b00};
    axi_req_o.aw_valid = aw_valid_q;
    axi_req_o.w.data   = wdata_q;
    axi_req_o.w.strb   = be_q;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid_q;
    axi_req_o.b_ready  = b_ready_q;
    axi_req_o.ar.id    = AXI_ID;
    axi_req_o.ar.addr  = addr_q;
    axi_req_o.ar.size  = AXI_SIZE_4B;
    axi_req_o.ar.burst = AXI_BURST_INCR;
    axi_req_o.ar.cache = AXI_CACHE_DEF;
    axi_req_o.ar.prot  = {IS_INSTR, 2'b00};
    axi_req_o.ar_valid = ar_valid_q;
    axi_req_o.r_ready  = r_ready_q;
  end

endmodule

// File: tb/tb_ibex_obi2axi.sv
// Directed bench for ibex_obi2axi: read, writes, split aw/w,
// back-to-back, error response and mid-transaction reset.
module tb_ibex_obi2axi;

  logic        clk;
  logic        rst;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  ibex_pkg::axi_req_t axi_req;
  ibex_pkg::axi_rsp_t axi_rsp;

  int checks = 0;
  int failures = 0;

`ifdef OBI2AXI_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  ibex_obi2axi #(
    .AXI_ID   (1'b0),
    .IS_INSTR (1'b0)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .gnt_o     (gnt),
    .we_i      (we),
    .be_i      (be),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rvalid_o  (rvalid),
    .rdata_o   (rdata),
    .err_o     (err),
    .axi_req_o (axi_req),
    .axi_rsp_i (axi_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ar_valid"}, 32'(axi_req.ar_valid), 0);
    chk({tag, " aw_valid"}, 32'(axi_req.aw_valid), 0);
    chk({tag, " w_valid"}, 32'(axi_req.w_valid), 0);
    chk({tag, " r_ready"}, 32'(axi_req.r_ready), 0);
    chk({tag, " b_ready"}, 32'(axi_req.b_ready), 0);
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    we = 1'b0;
    be = 4'h0;
    addr = '0;
    wdata = '0;
    axi_rsp = '0;
    repeat (2) cyc();
    rst = 1'b0;
    mid();
    chk_quiet("rst");
    chk("rst rvalid", 32'(rvalid), 0);
    chk("rst err", 32'(err), 0);
    chk("rst rdata", rdata, 0);
    chk("rst gnt", 32'(gnt), 0);
    cyc();

    // 1: zero-wait read
    axi_rsp.ar_ready = 1'b1;
    axi_rsp.r_valid = 1'b1;
    axi_rsp.r.data = 32'hDEADBEEF;
    req = 1'b1;
    we = 1'b0;
    be = 4'hF;
    addr = 32'h104;
    mid();
    chk("t1 gnt", 32'(gnt), 1);
    cyc();
    req = 1'b0;
    mid();
    chk("t1 ar_valid", 32'(axi_req.ar_valid), 1);
    chk("t1 ar.addr", axi_req.ar.addr, 32'h104);
    chk("t1 ar.len", 32'(axi_req.ar.len), 0);
    chk("t1 ar.size", 32'(axi_req.ar.size), 2);
    chk("t1 ar.burst", 32'(axi_req.ar.burst), 1);
    chk("t1 ar.cache", 32'(axi_req.ar.cache), 2);
    chk("t1 ar.prot", 32'(axi_req.ar.prot), 0);
    chk("t1 ar.id", 32'(axi_req.ar.id), 0);
    chk("t1 gnt busy", 32'(gnt), 0);
    chk("t1 r_ready T1", 32'(axi_req.r_ready), 0);
    cyc();
    mid();
    chk("t1 r_ready T2", 32'(axi_req.r_ready), 1);
    chk("t1 ar_valid T2", 32'(axi_req.ar_valid), 0);
    chk("t1 rvalid T2", 32'(rvalid), 0);
    cyc();
    axi_rsp = '0;
    mid();
    chk("t1 rvalid T3", 32'(rvalid), 1);
    chk("t1 rdata", rdata, 32'hDEADBEEF);
    chk("t1 err", 32'(err), 0);
    chk("t1 r_ready T3", 32'(axi_req.r_ready), 0);
    cyc();
    mid();
    chk("t1 rvalid T4", 32'(rvalid), 0);
    cyc();

    // 2: zero-wait write, unaligned address
    axi_rsp.aw_ready = 1'b1;
    axi_rsp.w_ready = 1'b1;
    axi_rsp.b_valid = 1'b1;
    req = 1'b1;
    we = 1'b1;
    be = 4'b0011;
    addr = 32'h203;
    wdata = 32'h12345678;
    mid();
    chk("t2 gnt", 32'(gnt), 1);
    cyc();
    req = 1'b0;
    mid();
    chk("t2 aw_valid", 32'(axi_req.aw_valid), 1);
    chk("t2 w_valid", 32'(axi_req.w_valid), 1);
    chk("t2 aw.addr", axi_req.aw.addr, 32'h200);
    chk("t2 w.strb", 32'(axi_req.w.strb), 3);
    chk("t2 w.last", 32'(axi_req.w.last), 1);
    chk("t2 w.data", axi_req.w.data, 32'h12345678);
    chk("t2 ar_valid", 32'(axi_req.ar_valid), 0);
    cyc();
    mid();
    chk("t2 b_ready", 32'(axi_req.b_ready), 1);
    chk("t2 aw_valid B", 32'(axi_req.aw_valid), 0);
    chk("t2 w_valid B", 32'(axi_req.w_valid), 0);
    chk("t2 rvalid B", 32'(rvalid), 0);
    cyc();
    axi_rsp = '0;
    mid();
    chk("t2 rvalid", 32'(rvalid), 1);
    chk("t2 rdata", rdata, 0);
    chk("t2 err", 32'(err), 0);
    cyc();
    mid();
    chk("t2 rvalid off", 32'(rvalid), 0);
    cyc();

    // 3: aw accepted three cycles before w
    axi_rsp.aw_ready = 1'b1;
    req = 1'b1;
    we = 1'b1;
    be = 4'hF;
    addr = 32'h300;
    wdata = 32'hA0B0C0D0;
    mid();
    chk("t3 gnt", 32'(gnt), 1);
    cyc();
    req = 1'b0;
    mid();
    chk("t3 aw_valid T1", 32'(axi_req.aw_valid), 1);
    chk("t3 w_valid T1", 32'(axi_req.w_valid), 1);
    cyc();
    mid();
    chk("t3 aw_valid T2", 32'(axi_req.aw_valid), 0);
    chk("t3 w_valid T2", 32'(axi_req.w_valid), 1);
    chk("t3 b_ready T2", 32'(axi_req.b_ready), 0);
    cyc();
    mid();
    chk("t3 w_valid T3", 32'(axi_req.w_valid), 1);
    chk("t3 w.data T3", axi_req.w.data, 32'hA0B0C0D0);
    chk("t3 b_ready T3", 32'(axi_req.b_ready), 0);
    cyc();
    axi_rsp.w_ready = 1'b1;
    mid();
    chk("t3 w_valid T4", 32'(axi_req.w_valid), 1);
    chk("t3 b_ready T4", 32'(axi_req.b_ready), 0);
    cyc();
    axi_rsp.w_ready = 1'b0;
    axi_rsp.b_valid = 1'b1;
    mid();
    chk("t3 b_ready T5", 32'(axi_req.b_ready), 1);
    chk("t3 w_valid T5", 32'(axi_req.w_valid), 0);
    chk("t3 rvalid T5", 32'(rvalid), 0);
    cyc();
    axi_rsp = '0;
    mid();
    chk("t3 rvalid T6", 32'(rvalid), 1);
    cyc();
    mid();
    chk("t3 rvalid T7", 32'(rvalid), 0);
    cyc();

    // 4: back-to-back read then write with req held
    axi_rsp.ar_ready = 1'b1;
    axi_rsp.r_valid = 1'b1;
    axi_rsp.r.data = 32'hCAFEF00D;
    axi_rsp.aw_ready = 1'b1;
    axi_rsp.w_ready = 1'b1;
    axi_rsp.b_valid = 1'b1;
    req = 1'b1;
    we = 1'b0;
    addr = 32'h500;
    mid();
    chk("t4 gnt rd", 32'(gnt), 1);
    cyc();
    we = 1'b1;
    addr = 32'h404;
    wdata = 32'h55AA55AA;
    be = 4'b1100;
    mid();
    chk("t4 gnt T1", 32'(gnt), 0);
    chk("t4 ar_valid T1", 32'(axi_req.ar_valid), 1);
    chk("t4 aw_valid T1", 32'(axi_req.aw_valid), 0);
    cyc();
    mid();
    chk("t4 gnt T2", 32'(gnt), 0);
    chk("t4 r_ready T2", 32'(axi_req.r_ready), 1);
    cyc();
    mid();
    chk("t4 rvalid T3", 32'(rvalid), 1);
    chk("t4 rdata T3", rdata, 32'hCAFEF00D);
    chk("t4 gnt wr T3", 32'(gnt), 1);
    chk("t4 ar_valid T3", 32'(axi_req.ar_valid), 0);
    chk("t4 aw_valid T3", 32'(axi_req.aw_valid), 0);
    cyc();
    req = 1'b0;
    mid();
    chk("t4 aw_valid T4", 32'(axi_req.aw_valid), 1);
    chk("t4 aw.addr T4", axi_req.aw.addr, 32'h404);
    chk("t4 w.strb T4", 32'(axi_req.w.strb), 4'b1100);
    chk("t4 ar_valid T4", 32'(axi_req.ar_valid), 0);
    chk("t4 rvalid T4", 32'(rvalid), 0);
    cyc();
    mid();
    chk("t4 b_ready T5", 32'(axi_req.b_ready), 1);
    cyc();
    axi_rsp = '0;
    mid();
    chk("t4 rvalid T6", 32'(rvalid), 1);
    chk("t4 rdata T6", rdata, 0);
    cyc();

    // 5: read with SLVERR
    axi_rsp.ar_ready = 1'b1;
    axi_rsp.r_valid = 1'b1;
    axi_rsp.r.data = 32'hA5A5A5A5;
    axi_rsp.r.resp = 2'b10;
    req = 1'b1;
    we = 1'b0;
    addr = 32'h600;
    mid();
    chk("t5 gnt", 32'(gnt), 1);
    cyc();
    req = 1'b0;
    cyc();
    cyc();
    axi_rsp = '0;
    mid();
    chk("t5 rvalid", 32'(rvalid), 1);
    chk("t5 err", 32'(err), ERR_EN ? 32'd1 : 32'd0);
    chk("t5 rdata", rdata, ERR_EN ? 32'd0 : 32'hA5A5A5A5);
    cyc();

    // 6: reset while R has r_valid pending
    axi_rsp.ar_ready = 1'b1;
    req = 1'b1;
    we = 1'b0;
    addr = 32'h700;
    mid();
    chk("t6 gnt", 32'(gnt), 1);
    cyc();
    req = 1'b0;
    cyc();
    axi_rsp.ar_ready = 1'b0;
    axi_rsp.r_valid = 1'b1;
    axi_rsp.r.data = 32'h0BADF00D;
    rst = 1'b1;
    mid();
    chk("t6 r_ready pend", 32'(axi_req.r_ready), 1);
    cyc();
    rst = 1'b0;
    axi_rsp = '0;
    axi_rsp.ar_ready = 1'b1;
    axi_rsp.r_valid = 1'b1;
    axi_rsp.r.data = 32'h11223344;
    req = 1'b1;
    addr = 32'h10;
    mid();
    chk_quiet("t6 post");
    chk("t6 rvalid post", 32'(rvalid), 0);
    chk("t6 idle gnt", 32'(gnt), 1);
    cyc();
    req = 1'b0;
    mid();
    chk("t6 rvalid +1", 32'(rvalid), 0);
    cyc();
    mid();
    chk("t6 rvalid +2", 32'(rvalid), 0);
    cyc();
    axi_rsp = '0;
    mid();
    chk("t6 new rvalid", 32'(rvalid), 1);
    chk("t6 new rdata", rdata, 32'h11223344);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
